sccb_init_sequencer: RTL

- Upstream controller for the SCCB master (CoreSCCB). After power-up it walks a register table of {sub_addr, data} pairs and issues one SCCB write per entry over the master's start/done handshake.
- Manages camera PWDN release, table delay entries, the inter-transaction bus-free gap and a per-transaction watchdog.
- Reports busy, done and error status to the system controller.

---
 rtl/sccb_init_sequencer_if.sv | 27 ++
 rtl/sccb_init_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_sequencer_if.sv
// SCCB master request/completion bundle between the init sequencer and CoreSCCB.
interface sccb_init_sequencer_if;
    logic       sccb_start;
    logic       sccb_rw;
    logic [7:0] sccb_ip_addr;
    logic [7:0] sccb_sub_addr;
    logic [7:0] sccb_data_in;
    logic       sccb_done;

    modport master (
        output sccb_start,
        output sccb_rw,
        output sccb_ip_addr,
        output sccb_sub_addr,
        output sccb_data_in,
        input  sccb_done
    );

    modport slave (
        input  sccb_start,
        input  sccb_rw,
        input  sccb_ip_addr,
        input  sccb_sub_addr,
        input  sccb_data_in,
        output sccb_done
    );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks a {sub_addr, data} register table after camera power-up and issues
// one SCCB write per entry, with delay entries, bus-free gaps and a watchdog.
module sccb_init_sequencer #(
    parameter logic [7:0] DEV_ADDR     = 8'h60,
    parameter int         ROM_AW       = 6,
    parameter int         PWRUP_CYCLES = 50000,
    parameter int         GAP_CYCLES   = 1000,
    parameter int         DELAY_UNIT   = 50000,
    parameter int         WDOG_CYCLES  = 2000000
) (
    input  logic                  XCLK,
    input  logic                  RST_N,
    input  logic                  init_start,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [15:0]           rom_data,
    sccb_init_sequencer_if.master sccb,
    output logic                  PWDN,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_error,
    output logic [ROM_AW:0]       entry_count
);

    localparam int MAX_A = (WDOG_CYCLES > PWRUP_CYCLES) ? WDOG_CYCLES : PWRUP_CYCLES;
    localparam int MAX_B = (GAP_CYCLES > 255 * DELAY_UNIT) ? GAP_CYCLES : 255 * DELAY_UNIT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE,
        S_GAP, S_DELAY, S_ADVANCE, S_DONE, S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ROM_AW-1:0]   addr_q, addr_d;
    logic [7:0]          sub_q, sub_d;
    logic [7:0]          dat_q, dat_d;
    logic                pwdn_q, pwdn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ROM_AW:0]     ec_q, ec_d;

    logic                is_end;
    logic                is_delay;
    logic [CW-1:0]       dly_load;

    assign is_end   = (rom_data == 16'hFFFF);
    assign is_delay = (rom_data[15:8] == 8'hFF) && !is_end;
    assign dly_load = CW'(int'(rom_data[7:0]) * DELAY_UNIT);

    always_ff @(posedge XCLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            sub_q   <= '0;
            dat_q   <= '0;
            pwdn_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sub_q   <= sub_d;
            dat_q   <= dat_d;
            pwdn_q  <= pwdn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ec_q    <= ec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (init_start) state_d = S_PWRUP;
            S_PWRUP:   if (cnt_q == CW'(PWRUP_CYCLES - 1)) state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                if (is_end)        state_d = S_DONE;
                else if (is_delay) state_d = S_DELAY;
                else               state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (sccb.sccb_done)                        state_d = S_GAP;
                else if (cnt_q == CW'(WDOG_CYCLES - 1))    state_d = S_ERROR;
            end
            S_GAP:     if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = S_ADVANCE;
            S_DELAY:   if (cnt_q == '0) state_d = S_ADVANCE;
            S_ADVANCE: state_d = (addr_q == '1) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            S_ERROR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        sub_d  = sub_q;
        dat_d  = dat_q;
        pwdn_d = pwdn_q;
        busy_d = busy_q;
        done_d = done_q;
        err_d  = err_q;
        ec_d   = ec_q;
        unique case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    pwdn_d = 1'b0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    ec_d   = '0;
                    addr_d = '0;
                    cnt_d  = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_q == CW'(PWRUP_CYCLES - 1)) cnt_d = '0;
                else                                 cnt_d = cnt_q + CW'(1);
            end
            S_FETCH: cnt_d = '0;
            S_DECODE: begin
                if (is_delay) begin
                    cnt_d = dly_load;
                end else if (!is_end) begin
                    sub_d = rom_data[15:8];
                    dat_d = rom_data[7:0];
                    cnt_d = '0;
                end
            end
            S_ISSUE: begin
                // Completion wins over a watchdog expiring on the same edge
                if (sccb.sccb_done) begin
                    ec_d  = ec_q + (ROM_AW+1)'(1);
                    cnt_d = '0;
                end else if (cnt_q == CW'(WDOG_CYCLES - 1)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) cnt_d = '0;
                else                               cnt_d = cnt_q + CW'(1);
            end
            S_DELAY: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            S_ADVANCE: if (addr_q != '1) addr_d = addr_q + ROM_AW'(1);
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            S_ERROR: begin
                busy_d = 1'b0;
                pwdn_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sccb.sccb_start    = (state_q == S_ISSUE);
        sccb.sccb_rw       = 1'b0;
        sccb.sccb_ip_addr  = DEV_ADDR;
        sccb.sccb_sub_addr = sub_q;
        sccb.sccb_data_in  = dat_q;
        rom_addr           = addr_q;
        PWDN               = pwdn_q;
        busy               = busy_q;
        init_done          = done_q;
        init_error         = err_q;
        entry_count        = ec_q;
    end

endmodule
